// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants for receiver, transmitter and FIFO
package uart_pkg;
    localparam int UART_DBIT           = 8;
    localparam int UART_FIFO_ADDR_W    = 4;
    localparam int UART_FIFO_AF_THRESH = 12;
endpackage

// File: rtl/uart_rx_fifo_if.sv
// rtl/uart_rx_fifo_if.sv - write/read/status bundle between UART receiver, host and RX FIFO
import uart_pkg::*;

interface uart_rx_fifo_if #(
    parameter int DBIT   = UART_DBIT,
    parameter int ADDR_W = UART_FIFO_ADDR_W
);
    logic              wr_en;
    logic [DBIT-1:0]   wr_data;
    logic              rd_en;
    logic              clr_overrun;
    logic [DBIT-1:0]   rd_data;
    logic              empty;
    logic              full;
    logic              almost_full;
    logic [ADDR_W:0]   count;
    logic              overrun;

    modport master (
        output wr_en, wr_data, rd_en, clr_overrun,
        input  rd_data, empty, full, almost_full, count, overrun
    );

    modport slave (
        input  wr_en, wr_data, rd_en, clr_overrun,
        output rd_data, empty, full, almost_full, count, overrun
    );
endinterface

// File: rtl/uart_fifo_ram.sv
// rtl/uart_fifo_ram.sv - register-array storage, one sync write port and one async read port
import uart_pkg::*;

module uart_fifo_ram #(
    parameter int DBIT   = UART_DBIT,
    parameter int ADDR_W = UART_FIFO_ADDR_W
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DBIT-1:0]   i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DBIT-1:0]   o_rdata
);
    // Storage is deliberately not reset; the pointers define what is valid.
    logic [DBIT-1:0] r_mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART receive FIFO with sticky overrun; UART_RX_FIFO_FWFT_EN selects fall-through read
import uart_pkg::*;

module uart_rx_fifo #(
    parameter int          DBIT      = UART_DBIT,
    parameter int          ADDR_W    = UART_FIFO_ADDR_W,
    parameter int unsigned AF_THRESH = UART_FIFO_AF_THRESH
) (
    input  logic           clk,
    input  logic           reset_n,
    uart_rx_fifo_if.slave  bus
);
    localparam logic [ADDR_W:0] LP_DEPTH = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] LP_AF    = AF_THRESH[ADDR_W:0];

    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic              r_overrun;

    logic              w_empty;
    logic              w_full;
    logic              w_wr_acc;
    logic              w_rd_acc;
    logic              w_ovr_set;
    logic [DBIT-1:0]   w_ram_rdata;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == LP_DEPTH);
    // A full FIFO still takes a write when a pop frees the slot in the same cycle.
    assign w_wr_acc  = bus.wr_en & (~w_full | bus.rd_en);
    assign w_rd_acc  = bus.rd_en & ~w_empty;
    assign w_ovr_set = bus.wr_en & w_full & ~bus.rd_en;

    uart_fifo_ram #(
        .DBIT   (DBIT),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_wr_acc),
        .i_waddr (r_wr_ptr),
        .i_wdata (bus.wr_data),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_ram_rdata)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            // Setting takes priority so a drop coinciding with a clear is not lost.
            if (w_ovr_set) begin
                r_overrun <= 1'b1;
            end else if (bus.clr_overrun) begin
                r_overrun <= 1'b0;
            end
        end
    end

`ifdef UART_RX_FIFO_FWFT_EN
    assign bus.rd_data = w_empty ? '0 : w_ram_rdata;
`else
    logic [DBIT-1:0] r_rd_data;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_data <= '0;
        end else if (w_rd_acc) begin
            r_rd_data <= w_ram_rdata;
        end
    end

    assign bus.rd_data = r_rd_data;
`endif

    assign bus.empty       = w_empty;
    assign bus.full        = w_full;
    assign bus.almost_full = (r_count >= LP_AF);
    assign bus.count       = r_count;
    assign bus.overrun     = r_overrun;
endmodule
